// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus requester port: state codes, tag layout
// and the default bus/line geometry.
package bus_pkg;

    localparam int unsigned DEF_BUS_DATA_WIDTH = 64;
    localparam int unsigned DEF_LINE_WIDTH     = 512;
    localparam int unsigned DEF_TAG_WIDTH      = 13;

    localparam int unsigned TAG_WRITE_BIT = 12;
    localparam int unsigned TAG_ID_MSB    = 11;
    localparam int unsigned TAG_ID_LSB    = 8;

    function automatic int unsigned calc_beats(input int unsigned line_w,
                                               input int unsigned bus_w);
        return line_w / bus_w;
    endfunction

    localparam int unsigned DEF_BEATS = calc_beats(DEF_LINE_WIDTH, DEF_BUS_DATA_WIDTH);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARB   = 3'd1;
    localparam state_t ST_ADDR  = 3'd2;
    localparam state_t ST_WDATA = 3'd3;
    localparam state_t ST_RRESP = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/bus_line_buffer.sv
// Beat-indexed cache-line store for read responses, plus the beat selector that
// feeds outgoing write-data beats from the captured write line.
module bus_line_buffer
    import bus_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
    parameter int unsigned BEATS          = DEF_BEATS,
    parameter int unsigned IDX_W          = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            we_i,
    input  logic [IDX_W-1:0]                idx_i,
    input  logic [BUS_DATA_WIDTH-1:0]       wbeat_i,
    input  logic [BEATS*BUS_DATA_WIDTH-1:0] src_line_i,
    output logic [BEATS*BUS_DATA_WIDTH-1:0] line_o,
    output logic [BUS_DATA_WIDTH-1:0]       src_beat_o
);

    logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] mem_q;
    logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] src_beats;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[idx_i] <= wbeat_i;
        end
    end

    assign src_beats  = src_line_i;
    assign src_beat_o = src_beats[idx_i];
    assign line_o     = mem_q;

endmodule

// File: rtl/bus_client_port.sv
// Requester endpoint of the shared system bus: takes one line read/write from a
// local client, arbitrates for the bus, runs the tagged handshake, then completes.
module bus_client_port
    import bus_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
    parameter int unsigned LINE_WIDTH     = DEF_LINE_WIDTH,
    parameter int unsigned TAG_WIDTH      = DEF_TAG_WIDTH,
    parameter logic [3:0]  CLIENT_ID      = 4'd0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cl_req_valid,
    output logic                      cl_req_ready,
    input  logic [63:0]               cl_req_addr,
    input  logic                      cl_req_write,
    input  logic [LINE_WIDTH-1:0]     cl_req_wdata,
    output logic                      cl_resp_valid,
    output logic [LINE_WIDTH-1:0]     cl_resp_data,
    output logic                      arb_req,
    input  logic                      arb_grant,
    output logic                      bus_busy_out,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [TAG_WIDTH-1:0]      bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [TAG_WIDTH-1:0]      bus_resptag,
    output logic                      bus_respack
);

    localparam int unsigned     BEATS     = calc_beats(LINE_WIDTH, BUS_DATA_WIDTH);
    localparam int unsigned     IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
    localparam logic [63:0]     ADDR_MASK = ~64'h3F;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic [63:0]               addr_q, addr_d;
    logic                      write_q, write_d;
    logic [LINE_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      beat_we;
    logic                      id_match;
    logic [BUS_DATA_WIDTH-1:0] wbeat;
    logic                      unused_tag_bits;

    // Only the client-id field routes responses; the remaining tag bits are opaque.
    assign id_match        = (bus_resptag[TAG_ID_MSB:TAG_ID_LSB] == CLIENT_ID);
    assign unused_tag_bits = ^{bus_resptag[TAG_WIDTH-1:TAG_ID_MSB+1],
                               bus_resptag[TAG_ID_LSB-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        beat_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cl_req_valid) begin
                    addr_d  = cl_req_addr & ADDR_MASK;
                    write_d = cl_req_write;
                    wdata_d = cl_req_wdata;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (arb_grant) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (bus_reqack) begin
                    cnt_d   = '0;
                    state_d = write_q ? ST_WDATA : ST_RRESP;
                end
            end
            ST_WDATA: begin
                if (bus_reqack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = ST_DONE;
                end
            end
            ST_RRESP: begin
                if (bus_respack) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    assign cl_req_ready  = (state_q == ST_IDLE);
    assign arb_req       = (state_q == ST_ARB);
    assign bus_busy_out  = (state_q == ST_ADDR) || (state_q == ST_WDATA) ||
                           (state_q == ST_RRESP) || (state_q == ST_DONE);
    assign bus_reqcyc    = (state_q == ST_ADDR) || (state_q == ST_WDATA);
    assign bus_respack   = (state_q == ST_RRESP) && bus_respcyc && id_match;
    assign cl_resp_valid = (state_q == ST_DONE);

    assign bus_req = (state_q == ST_ADDR)  ? BUS_DATA_WIDTH'(addr_q) :
                     (state_q == ST_WDATA) ? wbeat : '0;

    always_comb begin
        bus_reqtag = '0;
        if (bus_reqcyc) begin
            bus_reqtag[TAG_WRITE_BIT]          = write_q;
            bus_reqtag[TAG_ID_MSB:TAG_ID_LSB]  = CLIENT_ID;
        end
    end

    bus_line_buffer #(
        .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
        .BEATS         (BEATS),
        .IDX_W         (IDX_W)
    ) u_line_buffer (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .we_i      (beat_we),
        .idx_i     (cnt_q),
        .wbeat_i   (bus_resp),
        .src_line_i(wdata_q),
        .line_o    (cl_resp_data),
        .src_beat_o(wbeat)
    );

endmodule
